// File: rtl/mul17_stream_checker.sv
// mul17_stream_checker: verifies a counter/multiply-by-17 stream for product correctness and sequence continuity.
module mul17_stream_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [15:0]      in_mul,
  input  logic             clr,
  output logic             locked,
  output logic             prod_err,
  output logic             seq_err,
  output logic             wrap,
  output logic [15:0]      exp_mul,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail
);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  state_t state, state_nx;
  logic [3:0] run, run_nx;
  logic [7:0] last_a;
  logic [15:0] ref_mul, exp_nx;
  logic in_seq, reseed, pe, se, wr;
  always_comb begin
    ref_mul = {4'b0, in_a, 4'b0} + {8'b0, in_a};
    in_seq = in_a == 8'(last_a + 8'd1);
    reseed = state == IDLE || !in_seq;
    pe = in_mul != ref_mul;
    se = state == TRACK && !in_seq;
    wr = !reseed && last_a == 8'hff && in_a == 8'h00;
    exp_nx = in_a == 8'hff ? 16'd0 : (reseed ? ref_mul : exp_mul) + 16'd17;
    run_nx = reseed ? 4'd1 : (state == ACQ ? run + 4'd1 : run);
    state_nx = reseed ? ACQ : (state == ACQ && run_nx == 4'(LOCK_CNT) ? TRACK : state);
  end
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      state <= IDLE;
      run <= '0;
      last_a <= '0;
      locked <= 1'b0;
      prod_err <= 1'b0;
      seq_err <= 1'b0;
      wrap <= 1'b0;
      exp_mul <= '0;
      err_cnt <= '0;
      fail <= 1'b0;
    end else begin
      prod_err <= in_valid && pe;
      seq_err <= in_valid && se;
      wrap <= in_valid && wr;
      if (in_valid) begin
        state <= state_nx;
        run <= run_nx;
        last_a <= in_a;
        locked <= state_nx == TRACK;
        exp_mul <= exp_nx;
        if ((pe || se) && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
        fail <= fail | pe | se;
      end
    end
  end
endmodule

// File: doc/mul17_stream_checker.md
Name: mul17_stream_checker

Overview:
- Downstream consumer of the 8-bit counter / multiply-by-17 pair: samples each counter value and its 16-bit product.
- Checks every product against an independent shift-add reference, a*17 = {a,4'b0}+a.
- Checks that the counter sequence advances by exactly 1 modulo 256.
- Tracks lock state, pulses error and wrap events, and keeps a saturating error count for bench and in-system self-test.

Parameters:
- LOCK_CNT, default 4: consecutive in-sequence samples (seed included) required to enter TRACK; legal range 2..15.
- ERR_W, default 8: width of err_cnt.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; clock clk.
- in_valid  in  1  sample strobe; in_a/in_mul captured on a rising edge where in_valid=1.
- in_a  in  8  counter value.
- in_mul  in  16  multiplier product for in_a.
- clr  in  1  synchronous clear of state, counters and fail; lower priority than reset.
- locked  out  1  high while state is TRACK.
- prod_err  out  1  one-cycle pulse: in_mul != in_a*17.
- seq_err  out  1  one-cycle pulse: sequence break while in TRACK.
- wrap  out  1  one-cycle pulse: in-sequence step 255->0 accepted.
- exp_mul  out  16  expected product for the next sample, ((last_a+1) mod 256)*17.
- err_cnt  out  ERR_W  saturating count of errored samples.
- fail  out  1  sticky; set by any prod_err or seq_err.

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, locked=0, prod_err=0, seq_err=0, wrap=0, exp_mul=0, err_cnt=0, fail=0, run count=0, last_a=0. Reset mid-stream discards all history; the next valid sample is treated as a seed.
- clr=1 (reset=1): same effect as reset. A sample presented in the same cycle is ignored.
- All outputs are registered. Results for a sample accepted at edge N are visible after edge N, one-cycle latency. Pulses last exactly one cycle.
- No valid sample in a cycle: pulses return to 0; state, counts and exp_mul hold. Gaps between valid samples are legal.
- Reference product: ref = {in_a,4'b0} + {4'b0,in_a}, 16-bit, max 4335. prod_err=1 if in_mul != ref. Checked on every accepted sample in every state.
- In-sequence: in_a == last_a+1 mod 256.
- States:
  - IDLE: a valid sample seeds last_a=in_a, run=1, goes to ACQ.
  - ACQ: in-sequence sample gives run+1; run reaching LOCK_CNT goes to TRACK. Out-of-sequence sample reseeds, run=1, no seq_err.
  - TRACK: in-sequence sample stays in TRACK. Out-of-sequence sample gives seq_err=1, reseeds (last_a=in_a, run=1), goes to ACQ; locked drops after the same edge.
- prod_err does not affect state or run count.
- last_a updates on every accepted sample.
- exp_mul is updated on every accepted sample:
  - in-sequence: exp_mul+17, or 0 if in_a==255.
  - reseed: ref(in_a)+17, or 0 if in_a==255.
- wrap=1 when last_a==255, in_a==0, and the sample is in-sequence (ACQ or TRACK).
- err_cnt: +1 per sample with prod_err or seq_err (+1 only when both are set). Saturates at all-ones and never wraps.
- fail is set with err_cnt and cleared only by reset/clr.

Test Plan:
- Reset, then in_valid=1 with a=0,1,2,... and correct products: locked=0 after samples 1-3, locked=1 after sample 4; exp_mul=68 after a=3; err_cnt=0.
- Run a through 254,255,0,1: wrap pulses once after a=0 is accepted; exp_mul follows 4335, 0, 17, 34; locked stays 1; no errors.
- Locked, present a=10 with in_mul=171: prod_err pulse, err_cnt=1, fail=1, locked stays 1, exp_mul=187.
- Locked, skip from a=20 to a=22: seq_err pulse, locked=0, err_cnt+1; relock after a=23,24,25 (4 samples incl. 22).
- Force 300 errored samples (prod mismatch): err_cnt saturates at 255; then clr=1 for one cycle gives err_cnt=0, fail=0, state IDLE.
- Assert reset=0 mid-TRACK for one cycle with in_valid=1: all outputs 0; first sample after release reseeds, locked only after LOCK_CNT samples.
